// File: rtl/demosaicing_frame_ctrl.sv
// Frame-level sequencer ahead of the bilinear demosaicing core: gates the raw
// stream on frame boundaries, applies pending config at SOF, checks geometry.
module demosaicing_frame_ctrl #(
  parameter  int TDATA_WIDTH     = 16,
  parameter  int MAX_LINE_SIZE   = 1920,
  parameter  int MAX_FRAME_LINES = 1080,
  localparam int PXW             = $clog2(MAX_LINE_SIZE + 1),
  localparam int LNW             = $clog2(MAX_FRAME_LINES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   cfg_en_i,
  input  logic [1:0]             cfg_pattern_i,
  input  logic [PXW-1:0]         cfg_line_size_i,
  input  logic [LNW-1:0]         cfg_frame_lines_i,
  input  logic                   cfg_update_i,
  output logic [1:0]             pattern_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [15:0]            frame_cnt_o,
  output logic [2:0]             err_o,
  input  logic                   err_clr_i,
  input  logic [TDATA_WIDTH-1:0] s_tdata_i,
  input  logic                   s_tvalid_i,
  input  logic                   s_tlast_i,
  input  logic                   s_tuser_i,
  output logic                   s_tready_o,
  output logic [TDATA_WIDTH-1:0] m_tdata_o,
  output logic                   m_tvalid_o,
  output logic                   m_tlast_o,
  output logic                   m_tuser_o,
  input  logic                   m_tready_i
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, FLUSH} state_t;

  state_t         state;
  logic           pend_en;
  logic [1:0]     pend_pat;
  logic [PXW-1:0] pend_ls;
  logic [LNW-1:0] pend_fl;
  logic [PXW-1:0] act_ls;
  logic [LNW-1:0] act_fl;
  logic [PXW-1:0] px_cnt;
  logic [LNW-1:0] line_cnt;

  logic           counting, mid_sof, sof_wait, fwd, xfer, beat, load_cfg;
  logic           len_err, early_err, drop_err, frame_end;
  logic [PXW-1:0] px_base, px_next, lsz;
  logic [LNW-1:0] ln_base, ln_next, flz;

  always_comb begin
    counting = (state == ACTIVE) || (state == FLUSH);
    mid_sof  = counting && s_tuser_i && ((px_cnt != '0) || (line_cnt != '0));
    sof_wait = (state == WAIT_SOF) && pend_en && s_tuser_i;
    // An early SOF while flushing is swallowed rather than starting a frame.
    fwd      = sof_wait || (state == ACTIVE) || ((state == FLUSH) && !mid_sof);
  end

  assign m_tdata_o  = s_tdata_i;
  assign m_tlast_o  = s_tlast_i;
  assign m_tuser_o  = s_tuser_i;
  assign m_tvalid_o = fwd && s_tvalid_i;
  assign s_tready_o = fwd ? m_tready_i : 1'b1;

  always_comb begin
    xfer      = s_tvalid_i && s_tready_o;
    beat      = xfer && fwd;
    load_cfg  = beat && s_tuser_i;
    // The SOF beat is evaluated against the config it is about to load.
    px_base   = load_cfg ? '0 : px_cnt;
    ln_base   = load_cfg ? '0 : line_cnt;
    lsz       = load_cfg ? pend_ls : act_ls;
    flz       = load_cfg ? pend_fl : act_fl;
    px_next   = px_base + 1'b1;
    ln_next   = ln_base + 1'b1;
    len_err   = beat && (lsz != '0) && (s_tlast_i ? (px_next != lsz) : (px_next == lsz));
    frame_end = beat && s_tlast_i && (flz != '0) && (ln_next == flz);
    early_err = xfer && mid_sof;
    drop_err  = xfer && (state == WAIT_SOF) && pend_en && !s_tuser_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      pend_en      <= 1'b0;
      pend_pat     <= '0;
      pend_ls      <= '0;
      pend_fl      <= '0;
      pattern_o    <= '0;
      act_ls       <= '0;
      act_fl       <= '0;
      px_cnt       <= '0;
      line_cnt     <= '0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
      err_o        <= '0;
    end else begin
      if (cfg_update_i) begin
        pend_en  <= cfg_en_i;
        pend_pat <= cfg_pattern_i;
        pend_ls  <= cfg_line_size_i;
        pend_fl  <= cfg_frame_lines_i;
      end
      if (load_cfg) begin
        pattern_o <= pend_pat;
        act_ls    <= pend_ls;
        act_fl    <= pend_fl;
      end
      if (beat) begin
        px_cnt   <= s_tlast_i ? '0 : px_next;
        line_cnt <= s_tlast_i ? ln_next : ln_base;
      end
      frame_done_o <= frame_end;
      if (frame_end) frame_cnt_o <= frame_cnt_o + 16'd1;
      err_o <= (err_clr_i ? 3'b000 : err_o) | {drop_err, early_err, len_err};

      case (state)
        IDLE: if (pend_en) state <= WAIT_SOF;
        WAIT_SOF: begin
          if (!pend_en) state <= IDLE;
          else if (load_cfg && !frame_end) begin
            state  <= ACTIVE;
            busy_o <= 1'b1;
          end
        end
        ACTIVE: begin
          if (frame_end) begin
            state  <= pend_en ? WAIT_SOF : IDLE;
            busy_o <= 1'b0;
          end else if (!pend_en) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (frame_end || early_err) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
